// File: rtl/load_store_unit_pkg.sv
// Shared size encodings, FSM state type and lane-offset helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MEM  = 2'b01,
    RSP  = 2'b10
  } lsuState_e;

  // Number of address bits that select a byte lane inside one memory word.
  function automatic int lsuOffW(input int dataW);
    return $clog2(dataW / 8);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Big-endian byte-lane steering: store placement with byte enables, and load
// extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                 size,
  input  logic [lsuOffW(DATA_W)-1:0] offset,
  input  logic                       isSigned,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W-1:0]          rdata,
  output logic [DATA_W/8-1:0]        be,
  output logic [DATA_W-1:0]          laneWdata,
  output logic [DATA_W-1:0]          loadData
);

  localparam int OFF_W = lsuOffW(DATA_W);
  localparam int BE_W  = DATA_W / 8;

  logic [7:0]  byteLane_s;
  logic [15:0] halfLane_s;

  // Lane k sits (BE_W-1-k) lanes above bit 0, and BE_W-1-k is simply ~k.
  assign byteLane_s = 8'(rdata >> {~offset, 3'b000});
  assign halfLane_s = 16'(rdata >> {~offset[OFF_W-1:1], 4'b0000});

  // Select enables, placed store data and extended load data by access size.
  always_comb begin
    be        = {BE_W{1'b0}};
    laneWdata = {DATA_W{1'b0}};
    loadData  = {DATA_W{1'b0}};
    case (size)
      SZ_BYTE: begin
        be        = BE_W'(1'b1) << ~offset;
        laneWdata = DATA_W'(wdata[7:0]) << {~offset, 3'b000};
        loadData  = {{(DATA_W-8){isSigned & byteLane_s[7]}}, byteLane_s};
      end
      SZ_HALF: begin
        be        = BE_W'(2'b11) << {~offset[OFF_W-1:1], 1'b0};
        laneWdata = DATA_W'(wdata[15:0]) << {~offset[OFF_W-1:1], 4'b0000};
        loadData  = {{(DATA_W-16){isSigned & halfLane_s[15]}}, halfLane_s};
      end
      SZ_WORD: begin
        be        = {BE_W{1'b1}};
        laneWdata = wdata;
        loadData  = rdata;
      end
      default: begin
        be        = {BE_W{1'b0}};
        laneWdata = {DATA_W{1'b0}};
        loadData  = {DATA_W{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: execute-stage request -> word-aligned req/ack memory port -> response.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of truncating the offset.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_fault
);

  localparam int OFF_W = lsuOffW(DATA_W);
  localparam int BE_W  = DATA_W / 8;

  lsuState_e        state_r;
  logic             we_r;
  logic [1:0]       size_r;
  logic [OFF_W-1:0] off_r;
  logic             signed_r;

  logic [OFF_W-1:0]  reqOff_s;
  logic [OFF_W-1:0]  effOff_s;
  logic              reqFault_s;
  logic [BE_W-1:0]   stBe_s;
  logic [DATA_W-1:0] stWdata_s;
  logic [DATA_W-1:0] ldData_s;
  logic [DATA_W-1:0] unusedStLoad_s;
  logic [BE_W-1:0]   unusedLdBe_s;
  logic [DATA_W-1:0] unusedLdWdata_s;

  assign reqOff_s = req_addr[OFF_W-1:0];

  // Classify the incoming request and derive the lane offset actually used.
  always_comb begin
    effOff_s   = reqOff_s;
    reqFault_s = 1'b0;
    case (req_size)
      SZ_BYTE: begin
        effOff_s   = reqOff_s;
        reqFault_s = 1'b0;
      end
      SZ_HALF: begin
`ifdef LSU_MISALIGN_TRAP_EN
        effOff_s   = reqOff_s;
        reqFault_s = reqOff_s[0];
`else
        effOff_s   = {reqOff_s[OFF_W-1:1], 1'b0};
        reqFault_s = 1'b0;
`endif
      end
      SZ_WORD: begin
`ifdef LSU_MISALIGN_TRAP_EN
        effOff_s   = reqOff_s;
        reqFault_s = |reqOff_s;
`else
        effOff_s   = {OFF_W{1'b0}};
        reqFault_s = 1'b0;
`endif
      end
      default: begin
        effOff_s   = reqOff_s;
        reqFault_s = 1'b1;
      end
    endcase
  end

  lsu_lane_align #(.DATA_W(DATA_W)) uStoreAlign (
    .size      (req_size),
    .offset    (effOff_s),
    .isSigned  (1'b0),
    .wdata     (req_wdata),
    .rdata     ({DATA_W{1'b0}}),
    .be        (stBe_s),
    .laneWdata (stWdata_s),
    .loadData  (unusedStLoad_s)
  );

  lsu_lane_align #(.DATA_W(DATA_W)) uLoadAlign (
    .size      (size_r),
    .offset    (off_r),
    .isSigned  (signed_r),
    .wdata     ({DATA_W{1'b0}}),
    .rdata     (mem_rdata),
    .be        (unusedLdBe_s),
    .laneWdata (unusedLdWdata_s),
    .loadData  (ldData_s)
  );

  // Request/memory/response FSM; every port output is a register of this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      we_r      <= 1'b0;
      size_r    <= SZ_BYTE;
      off_r     <= {OFF_W{1'b0}};
      signed_r  <= 1'b0;
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_be    <= {BE_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_fault <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_r      <= req_we;
            size_r    <= req_size;
            off_r     <= effOff_s;
            signed_r  <= req_signed;
            if (reqFault_s) begin
              state_r   <= RSP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= {DATA_W{1'b0}};
            end else begin
              state_r   <= MEM;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= stBe_s;
              mem_wdata <= req_we ? stWdata_s : {DATA_W{1'b0}};
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            state_r   <= RSP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_be    <= {BE_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b0;
            rsp_rdata <= we_r ? {DATA_W{1'b0}} : ldData_s;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
          end
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 32-bit instance for the main scenarios and a
// 64-bit instance for wide lane steering.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;

  logic        reqValid64, reqReady64, reqWe64, reqSigned64;
  logic [31:0] reqAddr64;
  logic [63:0] reqWdata64;
  logic [1:0]  reqSize64;
  logic        memReq64, memWe64, memAck64;
  logic [31:0] memAddr64;
  logic [63:0] memWdata64, memRdata64;
  logic [7:0]  memBe64;
  logic        rspValid64, rspReady64, rspFault64;
  logic [63:0] rspRdata64;

  int compared   = 0;
  int mismatched = 0;

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid64), .req_ready(reqReady64), .req_we(reqWe64), .req_addr(reqAddr64),
    .req_wdata(reqWdata64), .req_size(reqSize64), .req_signed(reqSigned64),
    .mem_req(memReq64), .mem_we(memWe64), .mem_addr(memAddr64), .mem_be(memBe64),
    .mem_wdata(memWdata64), .mem_ack(memAck64), .mem_rdata(memRdata64),
    .rsp_valid(rspValid64), .rsp_ready(rspReady64), .rsp_rdata(rspRdata64), .rsp_fault(rspFault64)
  );

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 32-bit access: drive, serve the memory after ackWait idle MEM cycles, then
  // hold the response for rspHold cycles before accepting it.
  task automatic runAccess(
    input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [1:0] size, input logic sgn, input int ackWait, input logic [31:0] rdWord,
    input logic expMem, input logic [31:0] expAddr, input logic [3:0] expBe,
    input logic [31:0] expWd, input logic [31:0] expRd, input logic expFault,
    input int expLat, input int rspHold);
    int   n;
    int   memCycles;
    logic got;
    @(negedge clk);
    checkEq({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; memCycles = 0; got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      mem_ack = 1'b0;
      mem_rdata = 32'hDEAD_DEAD;
      if (rsp_valid) got = 1'b1;
      else if (mem_req) begin
        checkEq({tag, ".addr"}, mem_addr, expAddr);
        checkEq({tag, ".be"}, mem_be, expBe);
        checkEq({tag, ".wdata"}, mem_wdata, expWd);
        checkEq({tag, ".we"}, mem_we, we);
        if (memCycles == ackWait) begin
          mem_ack = 1'b1;
          mem_rdata = rdWord;
        end
        memCycles++;
      end
    end
    checkEq({tag, ".latency"}, n, expLat);
    checkEq({tag, ".memUsed"}, memCycles != 0, expMem);
    checkEq({tag, ".fault"}, rsp_fault, expFault);
    checkEq({tag, ".rdata"}, rsp_rdata, expRd);
    for (int h = 0; h < rspHold; h++) begin
      @(negedge clk);
      checkEq({tag, ".holdValid"}, rsp_valid, 1);
      checkEq({tag, ".holdRdata"}, rsp_rdata, expRd);
      checkEq({tag, ".holdReady"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkEq({tag, ".rspDone"}, rsp_valid, 0);
    checkEq({tag, ".readyBack"}, req_ready, 1);
  endtask

  // One 64-bit load with the ack in the first MEM cycle.
  task automatic run64(
    input string tag, input logic [31:0] addr, input logic [1:0] size, input logic sgn,
    input logic [63:0] rdWord, input logic [31:0] expAddr, input logic [7:0] expBe,
    input logic [63:0] expRd);
    @(negedge clk);
    reqValid64 = 1'b1; reqWe64 = 1'b0; reqAddr64 = addr; reqSize64 = size; reqSigned64 = sgn;
    @(posedge clk);
    #1 reqValid64 = 1'b0;
    @(negedge clk);
    checkEq({tag, ".memReq"}, memReq64, 1);
    checkEq({tag, ".addr"}, memAddr64, expAddr);
    checkEq({tag, ".be"}, memBe64, expBe);
    memAck64 = 1'b1; memRdata64 = rdWord;
    @(negedge clk);
    memAck64 = 1'b0;
    checkEq({tag, ".valid"}, rspValid64, 1);
    checkEq({tag, ".rdata"}, rspRdata64, expRd);
    checkEq({tag, ".fault"}, rspFault64, 0);
    rspReady64 = 1'b1;
    @(negedge clk);
    rspReady64 = 1'b0;
    checkEq({tag, ".readyBack"}, reqReady64, 1);
  endtask

  localparam logic [31:0] WORD = 32'h80FF_1234;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_size = 2'b00; req_signed = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; rsp_ready = 1'b0;
    reqValid64 = 1'b0; reqWe64 = 1'b0; reqAddr64 = 32'h0; reqWdata64 = 64'h0;
    reqSize64 = 2'b00; reqSigned64 = 1'b0; memAck64 = 1'b0; memRdata64 = 64'h0; rspReady64 = 1'b0;
    #1;
    checkEq("reset.ready", req_ready, 1);
    checkEq("reset.memReq", mem_req, 0);
    checkEq("reset.rspValid", rsp_valid, 0);
    checkEq("reset.ready64", reqReady64, 1);
    @(negedge clk);
    reset = 1'b0;

    //        tag           we    addr          wdata         size     sg  aw rdWord mem addr          be       wdata         rdata         flt lat hold
    runAccess("ldByteS",    1'b0, 32'h100, 32'h0,        SZ_BYTE, 1'b1, 0, WORD, 1'b1, 32'h100, 4'b1000, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 0);
    runAccess("ldHalfU",    1'b0, 32'h102, 32'h0,        SZ_HALF, 1'b0, 0, WORD, 1'b1, 32'h100, 4'b0011, 32'h0,        32'h0000_1234, 1'b0, 2, 0);
    runAccess("stByte",     1'b1, 32'h203, 32'h1234_56AB, SZ_BYTE, 1'b0, 3, WORD, 1'b1, 32'h200, 4'b0001, 32'h0000_00AB, 32'h0,        1'b0, 5, 0);
    runAccess("ldByteU",    1'b0, 32'h101, 32'h0,        SZ_BYTE, 1'b0, 0, WORD, 1'b1, 32'h100, 4'b0100, 32'h0,        32'h0000_00FF, 1'b0, 2, 0);
    runAccess("ldHalfS",    1'b0, 32'h100, 32'h0,        SZ_HALF, 1'b1, 0, WORD, 1'b1, 32'h100, 4'b1100, 32'h0,        32'hFFFF_80FF, 1'b0, 2, 0);
    runAccess("stHalf",     1'b1, 32'h102, 32'hDEAD_BEEF, SZ_HALF, 1'b0, 1, WORD, 1'b1, 32'h100, 4'b0011, 32'h0000_BEEF, 32'h0,        1'b0, 3, 0);
    runAccess("stWord",     1'b1, 32'h104, 32'hCAFE_F00D, SZ_WORD, 1'b0, 0, WORD, 1'b1, 32'h104, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 2, 0);
    runAccess("stByte0",    1'b1, 32'h200, 32'h0000_005A, SZ_BYTE, 1'b0, 0, WORD, 1'b1, 32'h200, 4'b1000, 32'h5A00_0000, 32'h0,        1'b0, 2, 0);
    runAccess("ldWordHold", 1'b0, 32'h100, 32'h0,        SZ_WORD, 1'b1, 0, WORD, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h80FF_1234, 1'b0, 2, 4);
    runAccess("ldRsvd",     1'b0, 32'h100, 32'h0,        SZ_RSVD, 1'b0, 0, WORD, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    runAccess("stRsvd",     1'b1, 32'h104, 32'hFFFF_FFFF, SZ_RSVD, 1'b0, 0, WORD, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    runAccess("misWord",    1'b0, 32'h101, 32'h0,        SZ_WORD, 1'b0, 0, WORD, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    runAccess("misHalf",    1'b0, 32'h103, 32'h0,        SZ_HALF, 1'b0, 0, WORD, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
`else
    runAccess("misWord",    1'b0, 32'h101, 32'h0,        SZ_WORD, 1'b0, 0, WORD, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h80FF_1234, 1'b0, 2, 0);
    runAccess("misHalf",    1'b0, 32'h103, 32'h0,        SZ_HALF, 1'b0, 0, WORD, 1'b1, 32'h100, 4'b0011, 32'h0,        32'h0000_1234, 1'b0, 2, 0);
`endif

    // Reset while the memory transaction is pending, then a stray ack.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h104; req_wdata = 32'h1111_2222;
    req_size = SZ_WORD; req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkEq("rst.preMemReq", mem_req, 1);
    reset = 1'b1;
    #1;
    checkEq("rst.memReq", mem_req, 0);
    checkEq("rst.memWe", mem_we, 0);
    checkEq("rst.memBe", mem_be, 0);
    checkEq("rst.memAddr", mem_addr, 0);
    checkEq("rst.memWdata", mem_wdata, 0);
    checkEq("rst.rspValid", rsp_valid, 0);
    checkEq("rst.rspRdata", rsp_rdata, 0);
    checkEq("rst.rspFault", rsp_fault, 0);
    checkEq("rst.ready", req_ready, 1);
    #1 reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = WORD;
    @(negedge clk);
    mem_ack = 1'b0;
    checkEq("stray.rspValid", rsp_valid, 0);
    checkEq("stray.memReq", mem_req, 0);
    @(negedge clk);
    checkEq("stray.rspValid2", rsp_valid, 0);
    checkEq("stray.ready", req_ready, 1);

    run64("w64.byte7",  32'h007, SZ_BYTE, 1'b0, 64'h0123_4567_89AB_CDEF, 32'h000, 8'h01, 64'h0000_0000_0000_00EF);
    run64("w64.halfC",  32'h00C, SZ_HALF, 1'b1, 64'h0123_4567_89AB_CDEF, 32'h008, 8'h0C, 64'hFFFF_FFFF_FFFF_89AB);
    run64("w64.byte10", 32'h010, SZ_BYTE, 1'b1, 64'h8100_0000_0000_0000, 32'h010, 8'h80, 64'hFFFF_FFFF_FFFF_FF81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
